// File: rtl/sar_conv_ctrl.sv
// SAR-ADC conversion sequencer: sampler timing, binary-search bit trials
// against the comparator, and a valid/ready result port with a sticky
// overrun flag.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; DAC parked at mid-scale
// ST_SAMPLE  | sampler switch closed for SAMPLE_CYCLES cycles
// ST_CONVERT | one bit trial per cycle, MSB first; last trial posts result
module sar_conv_ctrl #(
    parameter int NBITS         = 4,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic [NBITS-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overrun
);

    localparam int IDX_W = $clog2(NBITS);
    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    localparam logic [NBITS-1:0] MID      = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NBITS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAMPLE  = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sample_q, sample_d;
    logic [NBITS-1:0] dac_q, dac_d;
    logic             busy_q, busy_d;
    logic [NBITS-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             overrun_q, overrun_d;

    logic [NBITS-1:0] trial;
    logic             load;
    logic             xfer;

    // Next-state logic: sequencing, bit trials and result handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sample_d    = sample_q;
        dac_d       = dac_q;
        busy_d      = busy_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;
        trial       = dac_q;
        load        = 1'b0;
        xfer        = res_valid_q & res_ready;

        case (state_q)
            ST_IDLE: begin
                dac_d    = MID;
                sample_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    state_d  = ST_SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_LOAD;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d  = ST_CONVERT;
                    sample_d = 1'b0;
                    idx_d    = IDX_TOP;
                    dac_d    = MID;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CONVERT: begin
                // The bit under trial is currently 1, so the comparator
                // decision is exactly the value it keeps.
                trial[idx_q] = cmp_in;
                if (idx_q != '0) begin
                    trial[idx_q - 1'b1] = 1'b1;
                    idx_d = idx_q - 1'b1;
                    dac_d = trial;
                end else begin
                    load       = 1'b1;
                    res_data_d = trial;
                    dac_d      = MID;
                    if (start) begin
                        state_d  = ST_SAMPLE;
                        sample_d = 1'b1;
                        cnt_d    = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sample_d = 1'b0;
                busy_d   = 1'b0;
                dac_d    = MID;
            end
        endcase

        // A load on a transfer edge replaces the consumed result cleanly;
        // only a load over an unconsumed result counts as an overrun.
        if (load) begin
            res_valid_d = 1'b1;
            if (res_valid_q && !res_ready) begin
                overrun_d = 1'b1;
            end else if (xfer) begin
                overrun_d = 1'b0;
            end
        end else if (xfer) begin
            res_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // State registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sample_q    <= 1'b0;
            dac_q       <= MID;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sample_q    <= sample_d;
            dac_q       <= dac_d;
            busy_q      <= busy_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample    = sample_q;
    assign dac_code  = dac_q;
    assign busy      = busy_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Bench for sar_conv_ctrl: an analog comparator model, a reference model that
// predicts conversion timing and results from the binary-search rules, and a
// monitor that checks every output each cycle against that prediction.
module tb_sar_conv_ctrl;

    localparam int NB  = 4;
    localparam int SC  = 2;
    localparam int MID = 1 << (NB - 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic          cmp_in;
    logic          sample;
    logic [NB-1:0] dac_code;
    logic          busy;
    logic [NB-1:0] res_data;
    logic          res_valid;
    logic          res_ready;
    logic          overrun;

    sar_conv_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmp_in    (cmp_in),
        .sample    (sample),
        .dac_code  (dac_code),
        .busy      (busy),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int due;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // stimulus-side knobs, copied into the comparator model on acceptance
    int next_mode   = 0;    // 0 = analog value, 1 = comparator stuck 1, 2 = stuck 0
    int next_analog = 0;
    int cur_mode    = 0;
    int cur_analog  = 0;
    int cur_res     = 0;

    // reference model state
    int edge_n   = 0;
    int acc_edge = 0;
    int m_done   = 0;
    bit m_busy   = 0;
    bit m_valid  = 0;
    bit m_ovr    = 0;
    int m_data   = 0;
    bit rdy_at_edge = 0;
    bit new_edge    = 0;

    assign cmp_in = (cur_mode == 1) ? 1'b1 :
                    (cur_mode == 2) ? 1'b0 :
                    (cur_analog >= int'(dac_code));

    function automatic int expected_result(int mode, int analog);
        if (mode == 1) return (1 << NB) - 1;
        if (mode == 2) return 0;
        return analog;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_valid = 0;
        m_ovr   = 0;
        m_data  = 0;
        exp_q.delete();
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: decides which start requests are accepted and when each
    // result must appear, pushing the prediction onto the scoreboard.
    always @(posedge clk) begin
        if (rst) begin
            bit done_now;
            edge_n++;
            rdy_at_edge = res_ready;
            done_now = m_busy && (edge_n == m_done);
            if (done_now) m_busy = 0;
            if (!m_busy && start) begin
                exp_t e;
                m_busy     = 1;
                acc_edge   = edge_n;
                m_done     = edge_n + SC + NB;
                cur_mode   = next_mode;
                cur_analog = next_analog;
                cur_res    = expected_result(next_mode, next_analog);
                e.data     = cur_res;
                e.due      = m_done;
                exp_q.push_back(e);
            end
            new_edge = 1;
        end
    end

    // Monitor: applies the handshake rules, pops results as they fall due
    // and compares all outputs away from the active edge.
    always @(negedge clk) begin
        if (rst && new_edge) begin
            bit xfer;
            bit load;
            int k;
            int exp_dac;
            bit exp_sample;
            exp_t e;
            new_edge = 0;
            xfer = m_valid && rdy_at_edge;
            load = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
            if (load) begin
                e = exp_q.pop_front();
                if (m_valid && !xfer) m_ovr = 1;
                else if (xfer) m_ovr = 0;
                m_valid = 1;
                m_data  = e.data;
            end else if (xfer) begin
                m_valid = 0;
                m_ovr   = 0;
            end

            exp_sample = 0;
            exp_dac    = MID;
            if (m_busy) begin
                k = edge_n - acc_edge;
                if (k < SC) begin
                    exp_sample = 1;
                end else begin
                    k = k - SC;
                    exp_dac = ((cur_res >> (NB - k)) << (NB - k)) | (1 << (NB - 1 - k));
                end
            end

            check("busy", 32'(busy), 32'(m_busy));
            check("sample", 32'(sample), 32'(exp_sample));
            check("dac_code", 32'(dac_code), 32'(exp_dac));
            check("res_valid", 32'(res_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (m_valid) check("res_data", 32'(res_data), 32'(m_data));
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_sample"}, 32'(sample), 32'd0);
        check({tag, "_dac_code"}, 32'(dac_code), 32'(MID));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic one_conv(int mode, int analog, int gap);
        next_mode   = mode;
        next_analog = analog;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(gap);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        cyc(2);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // single conversion of 11, then comparator stuck high and low
        res_ready = 1'b1;
        one_conv(0, 11, 8);
        one_conv(1, 0, 7);
        one_conv(2, 0, 7);

        // back-to-back conversions with start held high
        next_mode   = 0;
        next_analog = 3;
        start = 1'b1;
        cyc(1);
        next_analog = 14;
        cyc(10);
        start = 1'b0;
        cyc(8);

        // two results without a consumer, then drain
        res_ready = 1'b0;
        one_conv(0, 5, 7);
        one_conv(0, 9, 7);
        check("overrun_set", 32'(overrun), 32'd1);
        res_ready = 1'b1;
        cyc(1);
        res_ready = 1'b0;
        cyc(2);
        check("overrun_clr", 32'(overrun), 32'd0);

        // start pulse while busy must be ignored
        res_ready = 1'b1;
        next_analog = 6;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(8);

        // reset in the middle of the bit trials
        next_analog = 7;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_reset();
        @(negedge clk);
        next_analog = 12;
        start = 1'b1;
        rst   = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(8);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            start       = ($urandom_range(0, 3) == 0);
            res_ready   = $urandom_range(0, 1);
            r           = $urandom_range(0, 9);
            next_mode   = (r < 8) ? 0 : (r == 8) ? 1 : 2;
            next_analog = $urandom_range(0, (1 << NB) - 1);
            cyc(1);
        end

        start     = 1'b0;
        res_ready = 1'b1;
        cyc(2 * (SC + NB) + 2);
        check("pending_results", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
